card_board: RTL and testbench

//  Responder to the game state machine. Owns the 12-card board (6 colour pairs, 4 cols x 3 rows).
//  - Shuffles colours on compute_colors_en and answers with compute_done.
//  - Hit-tests mouse clicks while wait_for_click_en is high; reports card_pressed, address and colour.
//  - Applies write_card_* commands and snapshots the board for the renderer on update_cards_en.

---
 rtl/card_board.sv | 209 ++++++++++++++++++++
 tb/tb_card_board.sv | 311 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/card_board.sv
// card_board: owns the 12-card memory-game board (shuffle, click hit-test, state writes, renderer snapshot).
// Define CARD_FIXED_LAYOUT_EN to skip the LFSR shuffle and keep card i at pair colour i/2.
module card_board #(
    parameter int          GRID_X0   = 144,
    parameter int          GRID_Y0   = 88,
    parameter int          CARD_W    = 160,
    parameter int          CARD_H    = 176,
    parameter int          CARD_GAP  = 32,
    parameter logic [15:0] LFSR_SEED = 16'hACE1,
    parameter logic [11:0] COLOR0    = 12'hF00,
    parameter logic [11:0] COLOR1    = 12'h0F0,
    parameter logic [11:0] COLOR2    = 12'h00F,
    parameter logic [11:0] COLOR3    = 12'hFF0,
    parameter logic [11:0] COLOR4    = 12'h0FF,
    parameter logic [11:0] COLOR5    = 12'hF0F
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        compute_colors_en,
    output logic        compute_done,
    input  logic        write_card_en,
    input  logic [1:0]  write_card_state,
    input  logic [3:0]  write_card_address,
    input  logic        update_cards_en,
    input  logic        wait_for_click_en,
    input  logic [11:0] mouse_xpos,
    input  logic [11:0] mouse_ypos,
    input  logic        mouse_left,
    output logic        card_pressed,
    output logic [3:0]  card_clicked_address,
    output logic [11:0] card_clicked_color,
    input  logic [3:0]  rd_address,
    output logic [1:0]  rd_state,
    output logic [11:0] rd_color
);
    localparam int         NUM_CARDS  = 12;
    localparam int         PITCH_X    = CARD_W + CARD_GAP;
    localparam int         PITCH_Y    = CARD_H + CARD_GAP;
    localparam logic [1:0] ST_COVERED = 2'b01;

    typedef enum logic [1:0] {IDLE, INIT, SHUFFLE, DONE} fsm_t;

    fsm_t        fsm, fsm_nxt;
    logic [15:0] lfsr;
    logic        compute_en_d, mouse_left_d;
    logic [3:0]  idx, pick;
    logic        swap_go, click_edge, accept, hit;
    logic [1:0]  hit_col, hit_row;
    logic [3:0]  hit_addr;
    logic [11:0] colors   [NUM_CARDS];
    logic [1:0]  states   [NUM_CARDS];
    logic [1:0]  states_nxt [NUM_CARDS];
    logic [1:0]  snapshot [NUM_CARDS];

    function automatic logic [11:0] pair_color(input int pair);
        case (pair)
            0:       return COLOR0;
            1:       return COLOR1;
            2:       return COLOR2;
            3:       return COLOR3;
            4:       return COLOR4;
            default: return COLOR5;
        endcase
    endfunction

    assign pick         = lfsr[3:0];
    assign swap_go      = (fsm == SHUFFLE) && compute_colors_en && (pick <= idx);
    assign compute_done = (fsm == DONE) && compute_colors_en;

    // Fibonacci LFSR, taps 16,14,13,11; free-running from reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) lfsr <= LFSR_SEED;
        else        lfsr <= {lfsr[14:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fsm          <= IDLE;
            compute_en_d <= 1'b0;
            idx          <= '0;
        end else begin
            fsm          <= fsm_nxt;
            compute_en_d <= compute_colors_en;
            if (fsm == INIT)  idx <= 4'd11;
            else if (swap_go) idx <= idx - 4'd1;
        end
    end

    // NOTE: next-state logic assigns its default first so no path can infer a latch.
    always_comb begin
        fsm_nxt = fsm;
        case (fsm)
            IDLE:    if (compute_colors_en && !compute_en_d) fsm_nxt = INIT;
            INIT: begin
                if (!compute_colors_en) fsm_nxt = IDLE;
                else begin
`ifdef CARD_FIXED_LAYOUT_EN
                    fsm_nxt = DONE;
`else
                    fsm_nxt = SHUFFLE;
`endif
                end
            end
            SHUFFLE: begin
                if (!compute_colors_en)         fsm_nxt = IDLE;
                else if (swap_go && idx == 4'd1) fsm_nxt = DONE;
            end
            DONE:    if (!compute_colors_en) fsm_nxt = IDLE;
            default: fsm_nxt = IDLE;
        endcase
    end

    // NOTE: the small board arrays are reset because the board must read back as empty after reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < NUM_CARDS; k++) colors[k] <= '0;
        end else if (fsm == INIT) begin
            for (int k = 0; k < NUM_CARDS; k++) colors[k] <= pair_color(k / 2);
        end else if (swap_go) begin
            colors[idx]  <= colors[pick];
            colors[pick] <= colors[idx];
        end
    end

    // Live next state is shared with the snapshot so a same-edge write is captured.
    always_comb begin
        for (int k = 0; k < NUM_CARDS; k++) states_nxt[k] = states[k];
        if (fsm == INIT) begin
            for (int k = 0; k < NUM_CARDS; k++) states_nxt[k] = ST_COVERED;
        end else if (write_card_en && fsm == IDLE && write_card_address < 4'(NUM_CARDS)) begin
            states_nxt[write_card_address] = write_card_state;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < NUM_CARDS; k++) begin
                states[k]   <= '0;
                snapshot[k] <= '0;
            end
        end else begin
            for (int k = 0; k < NUM_CARDS; k++) begin
                states[k] <= states_nxt[k];
                if (update_cards_en) snapshot[k] <= states_nxt[k];
            end
        end
    end

    always_comb begin
        int x_px, y_px;
        logic col_ok, row_ok;
        x_px    = int'(mouse_xpos);
        y_px    = int'(mouse_ypos);
        col_ok  = 1'b0;
        row_ok  = 1'b0;
        hit_col = '0;
        hit_row = '0;
        for (int c = 0; c < 4; c++) begin
            if (x_px >= GRID_X0 + c * PITCH_X && x_px < GRID_X0 + c * PITCH_X + CARD_W) begin
                col_ok  = 1'b1;
                hit_col = 2'(c);
            end
        end
        for (int r = 0; r < 3; r++) begin
            if (y_px >= GRID_Y0 + r * PITCH_Y && y_px < GRID_Y0 + r * PITCH_Y + CARD_H) begin
                row_ok  = 1'b1;
                hit_row = 2'(r);
            end
        end
        hit      = col_ok && row_ok;
        hit_addr = {hit_row, hit_col};
    end

    assign click_edge = mouse_left & ~mouse_left_d;
    // Uses the registered (pre-write) state, so a same-cycle write cannot mask the click.
    assign accept = click_edge && wait_for_click_en && (fsm == IDLE) && hit &&
                    (states[hit_addr] == ST_COVERED);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mouse_left_d         <= 1'b0;
            card_pressed         <= 1'b0;
            card_clicked_address <= '0;
            card_clicked_color   <= '0;
        end else begin
            mouse_left_d <= mouse_left;
            card_pressed <= accept;
            if (accept) begin
                card_clicked_address <= hit_addr;
                card_clicked_color   <= colors[hit_addr];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_state <= '0;
            rd_color <= '0;
        end else if (rd_address < 4'(NUM_CARDS)) begin
            rd_state <= snapshot[rd_address];
            rd_color <= colors[rd_address];
        end else begin
            rd_state <= '0;
            rd_color <= '0;
        end
    end

endmodule

// File: tb/tb_card_board.sv
// tb_card_board: directed and randomized checks of card_board against a behavioural board model.
// The model shuffles with a Fisher-Yates walk driven by its own copy of the free-running LFSR.
module tb_card_board;
    localparam logic [15:0] SEED = 16'hACE1;
    localparam int X0 = 144, Y0 = 88, W = 160, H = 176, GAP = 32;

    logic        clk = 1'b0, rst_n = 1'b0;
    logic        compute_colors_en = 1'b0, compute_done;
    logic        write_card_en = 1'b0;
    logic [1:0]  write_card_state = '0;
    logic [3:0]  write_card_address = '0;
    logic        update_cards_en = 1'b0, wait_for_click_en = 1'b0;
    logic [11:0] mouse_xpos = '0, mouse_ypos = '0;
    logic        mouse_left = 1'b0;
    logic        card_pressed;
    logic [3:0]  card_clicked_address;
    logic [11:0] card_clicked_color;
    logic [3:0]  rd_address = '0;
    logic [1:0]  rd_state;
    logic [11:0] rd_color;

    card_board dut (
        .clk(clk), .rst_n(rst_n),
        .compute_colors_en(compute_colors_en), .compute_done(compute_done),
        .write_card_en(write_card_en), .write_card_state(write_card_state),
        .write_card_address(write_card_address), .update_cards_en(update_cards_en),
        .wait_for_click_en(wait_for_click_en), .mouse_xpos(mouse_xpos), .mouse_ypos(mouse_ypos),
        .mouse_left(mouse_left), .card_pressed(card_pressed),
        .card_clicked_address(card_clicked_address), .card_clicked_color(card_clicked_color),
        .rd_address(rd_address), .rd_state(rd_state), .rd_color(rd_color)
    );

    always #5 clk = ~clk;

    int          n_checks = 0, n_pass = 0;
    logic [11:0] color_m [12];
    logic [1:0]  state_m [12];
    logic [1:0]  snap_m  [12];
    logic [3:0]  addr_m;
    logic [11:0] ccolor_m;
    logic [15:0] lfsr_m;

    function automatic logic [15:0] lfsr_step(input logic [15:0] l);
        return {l[14:0], l[15] ^ l[13] ^ l[12] ^ l[10]};
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) lfsr_m <= SEED;
        else        lfsr_m <= lfsr_step(lfsr_m);
    end

    function automatic logic [11:0] pal(input int p);
        case (p)
            0:       return 12'hF00;
            1:       return 12'h0F0;
            2:       return 12'h00F;
            3:       return 12'hFF0;
            4:       return 12'h0FF;
            default: return 12'hF0F;
        endcase
    endfunction

    // Card index under the pointer, or -1 for gaps and the area outside the grid.
    function automatic int hit_index(input int x, input int y);
        int c, r;
        if (x < X0 || y < Y0) return -1;
        c = (x - X0) / (W + GAP);
        r = (y - Y0) / (H + GAP);
        if (c > 3 || r > 2 || (x - X0) % (W + GAP) >= W || (y - Y0) % (H + GAP) >= H) return -1;
        return 4 * r + c;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic model_reset();
        for (int k = 0; k < 12; k++) begin
            color_m[k] = '0;
            state_m[k] = '0;
            snap_m[k]  = '0;
        end
        addr_m   = '0;
        ccolor_m = '0;
    endtask

    task automatic model_shuffle(input logic [15:0] start, output int n);
        logic [15:0] l;
        logic [11:0] t;
        int          i, j;
        for (int k = 0; k < 12; k++) begin
            color_m[k] = pal(k / 2);
            state_m[k] = 2'b01;
        end
        n = 0;
        l = start;
        i = 11;
`ifndef CARD_FIXED_LAYOUT_EN
        while (i > 0) begin
            j = int'(l[3:0]);
            if (j <= i) begin
                t          = color_m[i];
                color_m[i] = color_m[j];
                color_m[j] = t;
                i--;
            end
            l = lfsr_step(l);
            n++;
        end
`endif
    endtask

    task automatic run_shuffle(input string tag);
        logic [15:0] start;
        int          n, cnt;
        @(negedge clk) compute_colors_en = 1'b1;
        @(posedge clk);
        @(posedge clk);
        #1;
        start = lfsr_m;
        model_shuffle(start, n);
        cnt = 0;
        while (!compute_done && cnt < 2100) begin
            @(posedge clk);
            #1;
            cnt++;
        end
        check({tag, "_done"}, 32'(compute_done), 1);
        check({tag, "_latency"}, cnt, n);
        check({tag, "_bound"}, 32'(cnt <= 2048), 1);
    endtask

    task automatic end_request(input string tag);
        @(negedge clk) compute_colors_en = 1'b0;
        @(posedge clk);
        #1;
        check({tag, "_done_low"}, 32'(compute_done), 0);
    endtask

    task automatic rd_check(input string tag, input logic [3:0] a, output logic [11:0] got);
        logic [1:0]  exp_st;
        logic [11:0] exp_col;
        exp_st  = '0;
        exp_col = '0;
        if (a < 12) begin
            exp_st  = snap_m[a];
            exp_col = color_m[a];
        end
        @(negedge clk) rd_address = a;
        @(posedge clk);
        #1;
        check({tag, "_rd_state"}, 32'(rd_state), 32'(exp_st));
        check({tag, "_rd_color"}, 32'(rd_color), 32'(exp_col));
        got = rd_color;
    endtask

    // One command/click cycle followed by a release cycle.
    task automatic cyc(input string tag, input bit click, input int x, input int y,
                       input bit wr, input logic [1:0] wst, input logic [3:0] waddr,
                       input bit upd, input bit wait_en);
        int a;
        bit exp_p;
        @(negedge clk);
        mouse_xpos         = 12'(x);
        mouse_ypos         = 12'(y);
        mouse_left         = click;
        write_card_en      = wr;
        write_card_state   = wst;
        write_card_address = waddr;
        update_cards_en    = upd;
        wait_for_click_en  = wait_en;
        a     = hit_index(x, y);
        exp_p = click && wait_en && a >= 0;
        if (exp_p) exp_p = (state_m[a] == 2'b01);
        if (exp_p) begin
            addr_m   = 4'(a);
            ccolor_m = color_m[a];
        end
        if (wr && waddr < 12) state_m[waddr] = wst;
        if (upd) for (int k = 0; k < 12; k++) snap_m[k] = state_m[k];
        @(posedge clk);
        #1;
        check({tag, "_pressed"}, 32'(card_pressed), 32'(exp_p));
        check({tag, "_addr"}, 32'(card_clicked_address), 32'(addr_m));
        check({tag, "_color"}, 32'(card_clicked_color), 32'(ccolor_m));
        @(negedge clk);
        mouse_left        = 1'b0;
        write_card_en     = 1'b0;
        update_cards_en   = 1'b0;
        wait_for_click_en = 1'b0;
        @(posedge clk);
        #1;
        check({tag, "_pulse_end"}, 32'(card_pressed), 0);
    endtask

    initial begin
        logic [11:0] got;
        logic [11:0] seen [12];
        int          cnt;

        // Reset values.
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        check("rst_done", 32'(compute_done), 0);
        check("rst_pressed", 32'(card_pressed), 0);
        check("rst_addr", 32'(card_clicked_address), 0);
        check("rst_color", 32'(card_clicked_color), 0);
        check("rst_rd_state", 32'(rd_state), 0);
        check("rst_rd_color", 32'(rd_color), 0);
        @(negedge clk) rst_n = 1'b1;
        rd_check("rst_rd5", 4'd5, got);

        // First board; a write while DONE must be ignored.
        run_shuffle("req1");
        @(negedge clk);
        write_card_en      = 1'b1;
        write_card_address = 4'd0;
        write_card_state   = 2'b10;
        @(negedge clk);
        write_card_en      = 1'b0;
        compute_colors_en  = 1'b0;
        @(posedge clk);
        #1;
        check("req1_done_low", 32'(compute_done), 0);
        rd_check("pre_update5", 4'd5, got);
        cyc("update1", 0, 0, 0, 0, 2'b00, 4'd0, 1, 0);
        rd_check("post_update5", 4'd5, got);
        rd_check("post_update0", 4'd0, got);

        // Click on card 5, then again after it is uncovered.
        cyc("click5", 1, 400, 350, 0, 2'b00, 4'd0, 0, 1);
        cyc("write5", 0, 0, 0, 1, 2'b11, 4'd5, 0, 0);
        cyc("click5_again", 1, 400, 350, 0, 2'b00, 4'd0, 0, 1);

        // Gap, outside, and click with the enable low.
        cyc("gap", 1, 310, 350, 0, 2'b00, 4'd0, 0, 1);
        cyc("outside", 1, 1000, 10, 0, 2'b00, 4'd0, 0, 1);
        cyc("no_wait", 1, 200, 100, 0, 2'b00, 4'd0, 0, 0);

        // Writes to a valid and an out-of-range address, then snapshot.
        cyc("write3", 0, 0, 0, 1, 2'b10, 4'd3, 0, 0);
        cyc("write12", 0, 0, 0, 1, 2'b10, 4'd12, 1, 0);
        for (int a = 0; a < 16; a++) rd_check($sformatf("snap%0d", a), 4'(a), got);

        // Same-cycle write and click: the click sees the old state, the write still lands.
        cyc("wr_click6", 1, 538, 350, 1, 2'b11, 4'd6, 1, 1);
        cyc("click6_again", 1, 538, 350, 0, 2'b00, 4'd0, 0, 1);
        rd_check("snap6", 4'd6, got);

        // Random clicks, writes and snapshots.
        for (int k = 0; k < 40; k++) begin
            int x, y;
            if ($urandom_range(0, 3) != 0) begin
                x = X0 + int'($urandom_range(0, 3)) * (W + GAP) + int'($urandom_range(0, W - 1));
                y = Y0 + int'($urandom_range(0, 2)) * (H + GAP) + int'($urandom_range(0, H - 1));
            end else begin
                x = int'($urandom_range(0, 1000));
                y = int'($urandom_range(0, 800));
            end
            cyc($sformatf("rnd%0d", k), 1, x, y, $urandom_range(0, 3) == 0,
                2'($urandom_range(0, 3)), 4'($urandom_range(0, 13)),
                $urandom_range(0, 1) == 1, $urandom_range(0, 5) != 0);
        end
        for (int a = 0; a < 12; a++) rd_check($sformatf("rnd_snap%0d", a), 4'(a), got);

        // Repeated shuffles from different LFSR phases: exact colours and pair counts.
        for (int s = 0; s < 20; s++) begin
            repeat ($urandom_range(0, 40)) @(posedge clk);
            run_shuffle($sformatf("shuf%0d", s));
            end_request($sformatf("shuf%0d", s));
            for (int a = 0; a < 12; a++) begin
                rd_check($sformatf("shuf%0d_c%0d", s, a), 4'(a), got);
                seen[a] = got;
            end
            for (int p = 0; p < 6; p++) begin
                cnt = 0;
                for (int a = 0; a < 12; a++) if (seen[a] == pal(p)) cnt++;
                check($sformatf("shuf%0d_pair%0d", s, p), cnt, 2);
            end
        end

        // Reset in the middle of a shuffle.
        @(negedge clk) compute_colors_en = 1'b1;
        repeat (4) @(posedge clk);
        @(negedge clk);
        rst_n             = 1'b0;
        compute_colors_en = 1'b0;
        #1;
        model_reset();
        check("midrst_done", 32'(compute_done), 0);
        check("midrst_pressed", 32'(card_pressed), 0);
        check("midrst_addr", 32'(card_clicked_address), 0);
        check("midrst_rd_state", 32'(rd_state), 0);
        check("midrst_rd_color", 32'(rd_color), 0);
        @(negedge clk) rst_n = 1'b1;
        cyc("midrst_click", 1, 400, 350, 0, 2'b00, 4'd0, 0, 1);
        rd_check("midrst_rd5", 4'd5, got);
        run_shuffle("req_after_rst");
        end_request("req_after_rst");
        cyc("update2", 0, 0, 0, 0, 2'b00, 4'd0, 1, 0);
        rd_check("after_rst_rd5", 4'd5, got);
        cyc("after_rst_click5", 1, 400, 350, 0, 2'b00, 4'd0, 0, 1);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
